vga_seg_digit_renderer: RTL and testbench
=========================================

// Module: vga_seg_digit_renderer
// PURPOSE
//   Parametrised N-digit seven-segment renderer for the VGA stopwatch.
//   Draws each BCD digit as seven rectangular segments at a fixed screen position, from the
//   i_x/i_y scan coordinates of vga640x480. It replaces the hand-written per-segment assigns in
//   the top level.
//   Digit values are latched once per frame to prevent tearing. Colour and sync outputs are
//   pipelined and aligned, so they can drive the VGA pins directly.
// PARAMETERS
//   N_DIGITS   7      number of digits rendered (1..8)
//   X0         56     left x of digit 0 (pixels)
//   Y0         208    top y of all digits
//   PITCH      32     x distance between successive digit origins
//   DIG_W      24     digit cell width (PITCH > DIG_W)
//   DIG_H      48     digit cell height (even)
//   SEG_T      8      segment thickness (even, 2*SEG_T < DIG_W)
//   FG_RGB     15'h7FE0  lit colour {R[4:0],G[4:0],B[4:0]}; background is always 0
// PORTS
//   i_clk          in   1          system clock (100 MHz)
//   i_rst          in   1          synchronous reset, active-high
//   i_pix_stb      in   1          pixel strobe; the pipeline advances only when high
//   i_x            in   10         current pixel x
//   i_y            in   9          current pixel y
//   i_hs           in   1          raw hsync from the timing generator
//   i_vs           in   1          raw vsync from the timing generator
//   i_frame_start  in   1          1-strobe pulse at the first pixel of a frame
//   i_digits       in   4*N_DIGITS BCD digits; digit d = i_digits[4d+3:4d]; digit 0 is leftmost
//   i_blink_mask   in   N_DIGITS   per-digit blink enable (used only with SEG_BLINK_EN)
//   o_hs           out  1          i_hs delayed to align with the colour outputs
//   o_vs           out  1          i_vs delayed to align with the colour outputs
//   o_r            out  5          red
//   o_g            out  5          green
//   o_b            out  5          blue
//   o_pix_on       out  1          current output pixel is a lit segment
// BEHAVIOUR
//   - Reset (i_rst=1 at a clock edge, regardless of i_pix_stb):
//     - o_r/o_g/o_b/o_pix_on = 0; o_hs = o_vs = 1 (inactive).
//     - shadow digits = 0; pipeline valid/sync regs cleared; blink counter = 0.
//     - Reset mid-frame: output stays blank until the first post-reset frame_start latches digits.
//   - Registers update only on clock edges with i_pix_stb=1, except reset. With i_pix_stb=0 all
//     state holds.
//   - Shadow latch: on a strobe with i_frame_start=1, shadow <= i_digits. Other i_digits changes
//     are ignored for the rest of the frame. Reset has priority over a simultaneous frame_start.
//   - Stage 1 (strobe k):
//     - Find digit d with X0+d*PITCH <= x < X0+d*PITCH+DIG_W and Y0 <= y < Y0+DIG_H.
//     - Register hit, d, lx = x-X0-d*PITCH, ly = y-Y0.
//     - No multiplier or divider: the digit search is a compare loop over constants.
//   - Stage 2 (strobe k+1): segment decode of shadow[d] and hit test; registers the colour.
//     - Total latency is 2 strobes. o_hs/o_vs go through the same 2-stage delay.
//   - Segment regions (H2=DIG_H/2, W=DIG_W, H=DIG_H, T=SEG_T); corner squares are never lit:
//     - a: ly<T, T<=lx<W-T
//     - b: lx>=W-T, T<=ly<H2
//     - c: lx>=W-T, H2<=ly<H-T
//     - d: ly>=H-T, T<=lx<W-T
//     - e: lx<T, H2<=ly<H-T
//     - f: lx<T, T<=ly<H2
//     - g: H2-T/2<=ly<H2+T/2, T<=lx<W-T
//   - Decode: standard 0-9 patterns (7: a,b,c; 9 includes d). Invalid BCD 10-15 renders segment g
//     only (dash).
//   - Pixels outside every cell, or in gaps between cells: colour 0, o_pix_on=0.
//   - Coordinates beyond the 640x480 visible area never hit a cell; no special blanking is needed.
// CONFIGURATION
//   SEG_BLINK_EN:
//     - Defined:
//       - A 6-bit frame counter increments on each frame_start strobe and wraps 63->0.
//       - When counter[5]=1 (about 0.5 s at 60 Hz), digits with i_blink_mask[d]=1 render blank.
//       - i_blink_mask is sampled together with the shadow digits.
//     - Not defined: i_blink_mask is ignored, no counter exists, and all digits are always drawn.
// TESTING
//   1. Reset held 3 strobes -> o_r/o_g/o_b=0, o_hs=o_vs=1; after release, no lit pixel until
//      frame_start.
//   2. i_digits digit0=8, frame_start; pixel (68,210) -> o_pix_on=1 and {o_r,o_g,o_b}=15'h7FE0
//      exactly 2 strobes later. Pixel (56,208) (corner) -> 0.
//   3. digit0=1; pixel (68,210) (segment a) -> 0; pixel (76,220) (segment b) -> 1.
//      Pixel (84,210) (gap between cells) -> 0.
//   4. i_digits changed mid-frame from 0 to 1 -> rendering keeps showing 0 until the next
//      frame_start. Digit value 4'hC -> only segment g lit: (68,232)=1, (68,210)=0.
//   5. Stall i_pix_stb low 5 cycles mid-line -> outputs and o_hs/o_vs hold.
//      o_hs/o_vs always equal i_hs/i_vs delayed by 2 strobes.
//   6. SEG_BLINK_EN, mask=7'b0000001 -> digit0 dark during frames 32-63 and lit during 0-31;
//      digit1 always lit. Without the macro -> digit0 always lit.

Source files
------------

// File: rtl/vga_seg_digit_renderer.sv
// N-digit seven-segment renderer driven by the vga640x480 scan coordinates, 2-strobe colour/sync pipeline.
// Optional feature macro: SEG_BLINK_EN (per-digit blinking from a 6-bit frame counter).
module vga_seg_digit_renderer #(
    parameter int          N_DIGITS = 7,
    parameter int          X0       = 56,
    parameter int          Y0       = 208,
    parameter int          PITCH    = 32,
    parameter int          DIG_W    = 24,
    parameter int          DIG_H    = 48,
    parameter int          SEG_T    = 8,
    parameter logic [14:0] FG_RGB   = 15'h7FE0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pix_stb,
    input  logic [9:0]            i_x,
    input  logic [8:0]            i_y,
    input  logic                  i_hs,
    input  logic                  i_vs,
    input  logic                  i_frame_start,
    input  logic [4*N_DIGITS-1:0] i_digits,
    input  logic [N_DIGITS-1:0]   i_blink_mask,
    output logic                  o_hs,
    output logic                  o_vs,
    output logic [4:0]            o_r,
    output logic [4:0]            o_g,
    output logic [4:0]            o_b,
    output logic                  o_pix_on
);

    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int H2 = DIG_H / 2;

    logic [4*N_DIGITS-1:0] shadow;
    logic                  shadow_valid;
    logic                  hit_s1;
    logic [DW-1:0]         dig_s1;
    logic [9:0]            lx_s1;
    logic [8:0]            ly_s1;
    logic                  hs_s1, vs_s1;
    logic [14:0]           rgb;

    logic                  hit_n;
    logic [DW-1:0]         dig_n;
    logic [9:0]            lx_n;
    logic [8:0]            ly_n;
    logic [3:0]            cur_digit;
    logic [6:0]            seg_on;
    logic [6:0]            region;
    logic                  digit_blank;
    logic                  lit_n;

`ifdef SEG_BLINK_EN
    logic [5:0]            blink_cnt;
    logic [N_DIGITS-1:0]   blink_mask;
`else
    logic                  unused_blink;
    assign unused_blink = ^i_blink_mask;
`endif

    // Stage 1: locate the digit cell by comparing against each cell's constant x window.
    always_comb begin
        hit_n = 1'b0;
        dig_n = '0;
        lx_n  = '0;
        ly_n  = '0;
        if (int'(i_y) >= Y0 && int'(i_y) < Y0 + DIG_H) begin
            ly_n = i_y - 9'(Y0);
            for (int d = 0; d < N_DIGITS; d++) begin
                if (int'(i_x) >= X0 + d*PITCH && int'(i_x) < X0 + d*PITCH + DIG_W) begin
                    hit_n = 1'b1;
                    dig_n = DW'(d);
                    lx_n  = i_x - 10'(X0 + d*PITCH);
                end
            end
        end
    end

    // Stage 2: pick the latched digit, decode it and test the local position against each segment.
    always_comb begin
        cur_digit   = '0;
        digit_blank = 1'b0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (dig_s1 == DW'(d)) begin
                cur_digit = shadow[4*d +: 4];
`ifdef SEG_BLINK_EN
                digit_blank = blink_cnt[5] & blink_mask[d];
`endif
            end
        end

        case (cur_digit)           // {a,b,c,d,e,f,g}
            4'd0:    seg_on = 7'b1111110;
            4'd1:    seg_on = 7'b0110000;
            4'd2:    seg_on = 7'b1101101;
            4'd3:    seg_on = 7'b1111001;
            4'd4:    seg_on = 7'b0110011;
            4'd5:    seg_on = 7'b1011011;
            4'd6:    seg_on = 7'b1011111;
            4'd7:    seg_on = 7'b1110000;
            4'd8:    seg_on = 7'b1111111;
            4'd9:    seg_on = 7'b1111011;
            default: seg_on = 7'b0000001;
        endcase

        region[6] = (int'(ly_s1) < SEG_T) && (int'(lx_s1) >= SEG_T) && (int'(lx_s1) < DIG_W - SEG_T);
        region[5] = (int'(lx_s1) >= DIG_W - SEG_T) && (int'(ly_s1) >= SEG_T) && (int'(ly_s1) < H2);
        region[4] = (int'(lx_s1) >= DIG_W - SEG_T) && (int'(ly_s1) >= H2) && (int'(ly_s1) < DIG_H - SEG_T);
        region[3] = (int'(ly_s1) >= DIG_H - SEG_T) && (int'(lx_s1) >= SEG_T) && (int'(lx_s1) < DIG_W - SEG_T);
        region[2] = (int'(lx_s1) < SEG_T) && (int'(ly_s1) >= H2) && (int'(ly_s1) < DIG_H - SEG_T);
        region[1] = (int'(lx_s1) < SEG_T) && (int'(ly_s1) >= SEG_T) && (int'(ly_s1) < H2);
        region[0] = (int'(ly_s1) >= H2 - SEG_T/2) && (int'(ly_s1) < H2 + SEG_T/2)
                  && (int'(lx_s1) >= SEG_T) && (int'(lx_s1) < DIG_W - SEG_T);

        lit_n = hit_s1 & shadow_valid & ~digit_blank & (|(region & seg_on));
    end

    // shadow_valid keeps the screen dark after reset until digits have been latched once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow       <= '0;
            shadow_valid <= 1'b0;
            hit_s1       <= 1'b0;
            dig_s1       <= '0;
            lx_s1        <= '0;
            ly_s1        <= '0;
            hs_s1        <= 1'b1;
            vs_s1        <= 1'b1;
            o_hs         <= 1'b1;
            o_vs         <= 1'b1;
            o_pix_on     <= 1'b0;
            rgb          <= '0;
`ifdef SEG_BLINK_EN
            blink_cnt    <= '0;
            blink_mask   <= '0;
`endif
        end else if (i_pix_stb) begin
            hit_s1   <= hit_n;
            dig_s1   <= dig_n;
            lx_s1    <= lx_n;
            ly_s1    <= ly_n;
            hs_s1    <= i_hs;
            vs_s1    <= i_vs;
            o_hs     <= hs_s1;
            o_vs     <= vs_s1;
            o_pix_on <= lit_n;
            rgb      <= lit_n ? FG_RGB : 15'h0000;
            if (i_frame_start) begin
                shadow       <= i_digits;
                shadow_valid <= 1'b1;
`ifdef SEG_BLINK_EN
                blink_cnt    <= blink_cnt + 6'd1;
                blink_mask   <= i_blink_mask;
`endif
            end
        end
    end

    assign o_r = rgb[14:10];
    assign o_g = rgb[9:5];
    assign o_b = rgb[4:0];

endmodule

// File: tb/tb_vga_seg_digit_renderer.sv
// Randomised self-checking bench for vga_seg_digit_renderer against a behavioural pixel model.
// Honours SEG_BLINK_EN when it is defined for the whole build.
module tb_vga_seg_digit_renderer;

    localparam int N     = 7;
    localparam int X0    = 56;
    localparam int Y0    = 208;
    localparam int PITCH = 32;
    localparam int DIG_W = 24;
    localparam int DIG_H = 48;
    localparam int T     = 8;
    localparam logic [14:0] FG = 15'h7FE0;

    logic          clk = 1'b0;
    logic          rst, stb, hs, vs, fs;
    logic [9:0]    x;
    logic [8:0]    y;
    logic [4*N-1:0] digits;
    logic [N-1:0]  mask;
    logic          o_hs, o_vs, o_pix_on;
    logic [4:0]    o_r, o_g, o_b;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic [4*N-1:0] m_shadow;
    logic           m_valid;
    int             m_cnt;
    logic [N-1:0]   m_mask;
    logic           m_s1_have, m_s1_hs, m_s1_vs;
    int             m_s1_x, m_s1_y;
    logic           m_out_pix, m_out_hs, m_out_vs;

    string pats [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "g", "g", "g", "g", "g", "g"};

    always #5 clk = ~clk;

    vga_seg_digit_renderer dut (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_x(x), .i_y(y),
        .i_hs(hs), .i_vs(vs), .i_frame_start(fs), .i_digits(digits), .i_blink_mask(mask),
        .o_hs(o_hs), .o_vs(o_vs), .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_pix_on(o_pix_on)
    );

    function automatic byte seg_of(int lx, int ly);
        int h2 = DIG_H / 2;
        if (lx >= T && lx < DIG_W - T) begin
            if (ly < T) return "a";
            if (ly >= DIG_H - T) return "d";
            if (ly >= h2 - T/2 && ly < h2 + T/2) return "g";
            return 0;
        end
        if (ly < T || ly >= DIG_H - T) return 0;
        if (lx < T) return (ly < h2) ? "f" : "e";
        return (ly < h2) ? "b" : "c";
    endfunction

    function automatic logic ref_pix(int px, int py);
        int d, lx, ly, v;
        byte s;
        string p;
        if (!m_valid) return 1'b0;
        if (px < X0 || py < Y0 || py >= Y0 + DIG_H) return 1'b0;
        d  = (px - X0) / PITCH;
        lx = (px - X0) % PITCH;
        ly = py - Y0;
        if (d >= N || lx >= DIG_W) return 1'b0;
`ifdef SEG_BLINK_EN
        if (m_cnt >= 32 && m_mask[d]) return 1'b0;
`endif
        s = seg_of(lx, ly);
        if (s == 0) return 1'b0;
        v = int'(m_shadow[4*d +: 4]);
        p = pats[v];
        for (int i = 0; i < p.len(); i++)
            if (p[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input int px, input int py,
                                 input logic h, input logic v, input logic f,
                                 input logic [4*N-1:0] dg, input logic [N-1:0] mk);
        @(negedge clk);
        rst = r; stb = s; x = 10'(px); y = 9'(py); hs = h; vs = v; fs = f;
        digits = dg; mask = mk;
        @(posedge clk);
        if (r) begin
            m_out_pix = 1'b0; m_out_hs = 1'b1; m_out_vs = 1'b1;
            m_s1_have = 1'b0; m_s1_hs = 1'b1; m_s1_vs = 1'b1;
            m_shadow = '0; m_valid = 1'b0; m_cnt = 0; m_mask = '0;
        end else if (s) begin
            m_out_pix = m_s1_have ? ref_pix(m_s1_x, m_s1_y) : 1'b0;
            m_out_hs  = m_s1_hs;
            m_out_vs  = m_s1_vs;
            m_s1_have = 1'b1; m_s1_x = px; m_s1_y = py; m_s1_hs = h; m_s1_vs = v;
            if (f) begin
                m_shadow = dg; m_valid = 1'b1; m_cnt = (m_cnt + 1) % 64; m_mask = mk;
            end
        end
        #1;
        checkOutput("pix_on", 32'(o_pix_on), 32'(m_out_pix));
        checkOutput("rgb", 32'({o_r, o_g, o_b}), 32'(m_out_pix ? FG : 15'h0));
        checkOutput("hs", 32'(o_hs), 32'(m_out_hs));
        checkOutput("vs", 32'(o_vs), 32'(m_out_vs));
    endtask

    initial begin
        logic [4*N-1:0] fd;
        rst = 1'b1; stb = 1'b0; x = '0; y = '0; hs = 1'b1; vs = 1'b1; fs = 1'b0;
        digits = '0; mask = '0;

        // Reset with mixed strobe and a competing frame_start
        applyStimulus(1, 1, 68, 210, 0, 0, 1, 28'h8888888, '0);
        applyStimulus(1, 0, 68, 210, 0, 0, 1, 28'h8888888, '0);
        applyStimulus(1, 1, 68, 210, 1, 1, 0, 28'h8888888, '0);
        checkOutput("reset_hs_const", 32'(o_hs), 32'd1);

        // No lit pixel before the first frame_start
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 68, 210, 1, 1, 0, 28'h8888888, '0);

        // Digit 0 = 8: segment a lit, corner dark
        applyStimulus(0, 1, 0, 0, 1, 0, 1, 28'h0000008, '0);
        applyStimulus(0, 1, 68, 210, 1, 1, 0, 28'h0000008, '0);
        applyStimulus(0, 1, 56, 208, 1, 1, 0, 28'h0000008, '0);
        checkOutput("spec_d8_seg_a", 32'(o_pix_on), 32'd1);
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 28'h0000008, '0);
        checkOutput("spec_d8_corner", 32'(o_pix_on), 32'd0);

        // Digit 0 = 1, then a mid-frame change is ignored; then dash for 4'hC
        applyStimulus(0, 1, 0, 0, 1, 0, 1, 28'h0000001, '0);
        applyStimulus(0, 1, 68, 210, 1, 1, 0, 28'h0000001, '0);
        applyStimulus(0, 1, 76, 220, 1, 1, 0, 28'h0000001, '0);
        applyStimulus(0, 1, 84, 210, 1, 1, 0, 28'h0000001, '0);
        applyStimulus(0, 1, 0, 0, 1, 0, 1, 28'h0000000, '0);
        applyStimulus(0, 1, 68, 210, 1, 1, 0, 28'h0000001, '0);
        applyStimulus(0, 1, 76, 220, 0, 1, 0, 28'h0000001, '0);
        applyStimulus(0, 1, 0, 0, 1, 0, 1, 28'h000000C, '0);
        applyStimulus(0, 1, 68, 232, 1, 1, 0, 28'h000000C, '0);
        applyStimulus(0, 1, 68, 210, 1, 0, 0, 28'h000000C, '0);

        // Stall mid-line with toggling sync inputs
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 76, 220, i[0], ~i[0], 0, 28'h000000C, '0);
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 28'h000000C, '0);
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 28'h000000C, '0);

        // Randomised frames, long enough for the blink counter to wrap
        for (int f = 0; f < 80; f++) begin
            fd = 28'($urandom);
            applyStimulus(0, 1, 0, 0, 1, 0, 1, fd, N'($urandom));
            for (int p = 0; p < 50; p++) begin
                if (f == 40 && p == 20)
                    applyStimulus(1, 1, 70, 220, 1, 1, 0, fd, '0);
                else
                    applyStimulus(0, ($urandom_range(9, 0) != 0), $urandom_range(300, 40),
                                  $urandom_range(265, 195), 1'($urandom), 1'($urandom),
                                  0, 28'($urandom), N'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
